// File: rtl/demo_sequencer.sv
`timescale 1ns/1ps
// demo_sequencer: frame-driven scene sequencer for the demo intro.
// Counts frames, walks the scene list FLASH..END at fixed entry frames,
// and produces registered animation parameters for the video pipeline.
// Optional feature macro: DEMO_SEQ_SKIP_EN adds skip_req and a sticky
// skip flag that jumps to the next scene on the following frame_tick.
module demo_sequencer #(
  parameter int SCROLL_IN_START = 100,
  parameter int SCROLL_LEN      = 69,
  parameter int PLANE_IN_START  = 209,
  parameter int PLANE_LEN       = 240,
  parameter int PLANE_OUT_END   = 1671
) (
  input  logic        clk48,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic [7:0]  songpos,
`ifdef DEMO_SEQ_SKIP_EN
  input  logic        skip_req,
`endif
  output logic [10:0] frame,
  output logic [3:0]  scene,
  output logic [11:0] scrollh_anim,
  output logic [8:0]  plane_y_start,
  output logic [5:0]  flash_level
);

  typedef enum logic [3:0] {
    S_FLASH      = 4'd0,
    S_SKY        = 4'd1,
    S_SCROLL_IN  = 4'd2,
    S_PRE_PLANE  = 4'd3,
    S_PLANE_IN   = 4'd4,
    S_HOLD       = 4'd5,
    S_SCROLL_OUT = 4'd6,
    S_PLANE_OUT  = 4'd7,
    S_END        = 4'd8
  } scene_t;

  // Entry frame of each scene after FLASH.
  localparam logic [10:0] E_SKY        = 11'd32;
  localparam logic [10:0] E_SCROLL_IN  = 11'(SCROLL_IN_START);
  localparam logic [10:0] E_PRE_PLANE  = 11'(SCROLL_IN_START + SCROLL_LEN);
  localparam logic [10:0] E_PLANE_IN   = 11'(PLANE_IN_START);
  localparam logic [10:0] E_HOLD       = 11'(PLANE_IN_START + PLANE_LEN);
  localparam logic [10:0] E_SCROLL_OUT = 11'(PLANE_OUT_END - PLANE_LEN - SCROLL_LEN);
  localparam logic [10:0] E_PLANE_OUT  = 11'(PLANE_OUT_END - PLANE_LEN);
  localparam logic [10:0] E_END        = 11'(PLANE_OUT_END);

  scene_t      scene_reg, scene_next, succ_scene;
  logic [10:0] frame_reg, frame_next, frame_inc, succ_entry;
  logic [8:0]  n_reg, n_next;
  logic        restart;
  logic        skip_reg, skip_next;

  logic [11:0] scroll_reg, scroll_next;
  logic [8:0]  plane_reg, plane_next;
  logic [5:0]  flash_reg, flash_next;

  // Successor scene and the frame at which it begins.
  always_comb begin
    succ_scene = S_END;
    succ_entry = E_END;
    case (scene_reg)
      S_FLASH:      begin succ_scene = S_SKY;        succ_entry = E_SKY;        end
      S_SKY:        begin succ_scene = S_SCROLL_IN;  succ_entry = E_SCROLL_IN;  end
      S_SCROLL_IN:  begin succ_scene = S_PRE_PLANE;  succ_entry = E_PRE_PLANE;  end
      S_PRE_PLANE:  begin succ_scene = S_PLANE_IN;   succ_entry = E_PLANE_IN;   end
      S_PLANE_IN:   begin succ_scene = S_HOLD;       succ_entry = E_HOLD;       end
      S_HOLD:       begin succ_scene = S_SCROLL_OUT; succ_entry = E_SCROLL_OUT; end
      S_SCROLL_OUT: begin succ_scene = S_PLANE_OUT;  succ_entry = E_PLANE_OUT;  end
      S_PLANE_OUT:  begin succ_scene = S_END;        succ_entry = E_END;        end
      default:      begin succ_scene = S_END;        succ_entry = E_END;        end
    endcase
  end

  // Next-state: restart beats skip, skip beats the frame-driven transition.
  always_comb begin
    frame_inc  = (frame_reg == 11'h7FF) ? frame_reg : frame_reg + 11'd1;
    restart    = (songpos == 8'd0) && (frame_reg > 11'd8);
    scene_next = scene_reg;
    frame_next = frame_reg;
    n_next     = n_reg;
`ifdef DEMO_SEQ_SKIP_EN
    // A pending flag is consumed by any tick; a new request re-arms it.
    skip_next  = (skip_reg && !frame_tick) || skip_req;
`else
    skip_next  = 1'b0;
`endif
    if (frame_tick) begin
      if (restart) begin
        scene_next = S_FLASH;
        frame_next = 11'd0;
        n_next     = 9'd0;
      end else if (skip_reg && (scene_reg != S_END)) begin
        scene_next = succ_scene;
        frame_next = succ_entry;
        n_next     = 9'd0;
      end else if ((scene_reg != S_END) && (frame_inc == succ_entry)) begin
        scene_next = succ_scene;
        frame_next = frame_inc;
        n_next     = 9'd0;
      end else begin
        frame_next = frame_inc;
        n_next     = n_reg + 9'd1;
      end
    end
  end

  // Animation parameters derived from the state being entered this edge.
  always_comb begin
    case (scene_next)
      S_SCROLL_IN:                 scroll_next = 12'd2444 + {n_next[7:0], 4'h0};
      S_PRE_PLANE, S_PLANE_IN,
      S_HOLD:                      scroll_next = 12'd3548;
      S_SCROLL_OUT:                scroll_next = 12'd3548 + {n_next[7:0], 4'h0};
      default:                     scroll_next = 12'd2048;
    endcase
    case (scene_next)
      S_FLASH, S_SKY, S_SCROLL_IN,
      S_PRE_PLANE:                 plane_next = 9'd480;
      S_PLANE_IN:                  plane_next = 9'd480 - n_next;
      S_HOLD, S_SCROLL_OUT:        plane_next = 9'd240;
      S_PLANE_OUT:                 plane_next = 9'd240 - n_next;
      default:                     plane_next = 9'd0;
    endcase
    flash_next = (scene_next == S_FLASH) ? (6'd63 - {frame_next[4:0], 1'b0}) : 6'd0;
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      scene_reg  <= S_FLASH;
      frame_reg  <= 11'd0;
      n_reg      <= 9'd0;
      skip_reg   <= 1'b0;
      scroll_reg <= 12'd2048;
      plane_reg  <= 9'd480;
      flash_reg  <= 6'd63;
    end else begin
      scene_reg  <= scene_next;
      frame_reg  <= frame_next;
      n_reg      <= n_next;
      skip_reg   <= skip_next;
      scroll_reg <= scroll_next;
      plane_reg  <= plane_next;
      flash_reg  <= flash_next;
    end
  end

  assign frame         = frame_reg;
  assign scene         = scene_reg;
  assign scrollh_anim  = scroll_reg;
  assign plane_y_start = plane_reg;
  assign flash_level   = flash_reg;

endmodule

// File: tb/tb_demo_sequencer.sv
`timescale 1ns/1ps
// tb_demo_sequencer: directed checkpoints pushed into a scoreboard queue;
// a monitor pops one entry per registered frame_tick and compares.
module tb_demo_sequencer;

  logic        clk48 = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic [7:0]  songpos;
`ifdef DEMO_SEQ_SKIP_EN
  logic        skip_req;
`endif
  logic [10:0] frame;
  logic [3:0]  scene;
  logic [11:0] scrollh_anim;
  logic [8:0]  plane_y_start;
  logic [5:0]  flash_level;

  demo_sequencer dut (
    .clk48         (clk48),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .songpos       (songpos),
`ifdef DEMO_SEQ_SKIP_EN
    .skip_req      (skip_req),
`endif
    .frame         (frame),
    .scene         (scene),
    .scrollh_anim  (scrollh_anim),
    .plane_y_start (plane_y_start),
    .flash_level   (flash_level)
  );

  always #5 clk48 = ~clk48;

  typedef struct {
    logic        full;
    logic        chk_frame;
    logic [10:0] frame;
    logic [3:0]  scene;
    logic [11:0] scroll;
    logic [8:0]  plane;
    logic [5:0]  flash;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_frame = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every tick seen at a rising edge yields one scoreboard entry.
  always @(posedge clk48) begin
    if (rst_n && frame_tick) begin
      #1;
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        cur = exp_q.pop_front();
        if (cur.chk_frame) check("frame", 32'(frame), 32'(cur.frame));
        if (cur.full) begin
          check("scene",         32'(scene),         32'(cur.scene));
          check("scrollh_anim",  32'(scrollh_anim),  32'(cur.scroll));
          check("plane_y_start", 32'(plane_y_start), 32'(cur.plane));
          check("flash_level",   32'(flash_level),   32'(cur.flash));
          $display("tick frame=%0d scene=%0d scrollh=%0d plane_y=%0d flash=%0d",
                   frame, scene, scrollh_anim, plane_y_start, flash_level);
        end
      end
    end
  end

  task automatic push_tick(input logic [7:0] sp, input exp_t e);
    @(negedge clk48);
    songpos    = sp;
    frame_tick = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk48);
      frame_tick = 1'b0;
    end
  endtask

  // Back-to-back ticks up to target, checking only the frame count.
  task automatic run_to(input int target, input logic [7:0] sp);
    exp_t e;
    while (exp_frame < target) begin
      exp_frame++;
      e.full = 1'b0; e.chk_frame = 1'b1; e.frame = 11'(exp_frame);
      e.scene = '0; e.scroll = '0; e.plane = '0; e.flash = '0;
      push_tick(sp, e);
    end
  endtask

  task automatic tick_full(input logic [7:0] sp, input int f, input int sc,
                           input int sr, input int pl, input int fl);
    exp_t e;
    exp_frame = f;
    e.full = 1'b1; e.chk_frame = 1'b1; e.frame = 11'(f);
    e.scene = 4'(sc); e.scroll = 12'(sr); e.plane = 9'(pl); e.flash = 6'(fl);
    push_tick(sp, e);
  endtask

`ifdef DEMO_SEQ_SKIP_EN
  task automatic skip_pulse();
    @(negedge clk48);
    frame_tick = 1'b0;
    skip_req   = 1'b1;
    @(negedge clk48);
    skip_req   = 1'b0;
  endtask

  task automatic tick_noframe(input logic [7:0] sp, input int sc,
                              input int sr, input int pl, input int fl);
    exp_t e;
    e.full = 1'b1; e.chk_frame = 1'b0; e.frame = '0;
    e.scene = 4'(sc); e.scroll = 12'(sr); e.plane = 9'(pl); e.flash = 6'(fl);
    push_tick(sp, e);
  endtask
`endif

  task automatic check_reset_values(input string tag);
    check({tag, "_frame"},  32'(frame),         32'd0);
    check({tag, "_scene"},  32'(scene),         32'd0);
    check({tag, "_scroll"}, 32'(scrollh_anim),  32'd2048);
    check({tag, "_plane"},  32'(plane_y_start), 32'd480);
    check({tag, "_flash"},  32'(flash_level),   32'd63);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    songpos    = 8'd5;
`ifdef DEMO_SEQ_SKIP_EN
    skip_req   = 1'b0;
`endif
    repeat (3) @(negedge clk48);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Intro flash fades 63,61,...,1, then SKY at frame 32.
    for (int i = 1; i <= 31; i++) begin
      tick_full(8'd5, i, 0, 2048, 480, 63 - 2 * i);
      if (i % 4 == 0) idle(2);
    end
    tick_full(8'd5, 32, 1, 2048, 480, 0);

    // Scroller entry and exit boundaries.
    run_to(99, 8'd5);
    tick_full(8'd5, 100, 2, 2444, 480, 0);
    run_to(167, 8'd5);
    tick_full(8'd5, 168, 2, 3532, 480, 0);
    tick_full(8'd5, 169, 3, 3548, 480, 0);
    run_to(208, 8'd5);
    tick_full(8'd5, 209, 4, 3548, 480, 0);
    run_to(328, 8'd5);
    tick_full(8'd5, 329, 4, 3548, 360, 0);
    run_to(448, 8'd5);
    tick_full(8'd5, 449, 5, 3548, 240, 0);
    run_to(1361, 8'd5);
    tick_full(8'd5, 1362, 6, 3548, 240, 0);
    run_to(1429, 8'd5);
    tick_full(8'd5, 1430, 6, 540, 240, 0);
    tick_full(8'd5, 1431, 7, 2048, 240, 0);
    tick_full(8'd5, 1432, 7, 2048, 239, 0);
    run_to(1670, 8'd5);
    tick_full(8'd5, 1671, 8, 2048, 0, 0);

    // Frame counter saturates at 2047 while END persists.
    run_to(2047, 8'd5);
    tick_full(8'd5, 2047, 8, 2048, 0, 0);

    // Restart from END, then the frame>8 boundary of the restart rule.
    tick_full(8'd0, 0, 0, 2048, 480, 63);
    run_to(5, 8'd5);
    tick_full(8'd0, 6, 0, 2048, 480, 51);
    tick_full(8'd0, 7, 0, 2048, 480, 49);
    tick_full(8'd0, 8, 0, 2048, 480, 47);
    tick_full(8'd0, 9, 0, 2048, 480, 45);
    tick_full(8'd0, 0, 0, 2048, 480, 63);
    run_to(499, 8'd5);
    tick_full(8'd5, 500, 5, 3548, 240, 0);
    tick_full(8'd0, 0, 0, 2048, 480, 63);

    // Asynchronous reset in HOLD, checked before any further clock edge.
    run_to(459, 8'd5);
    tick_full(8'd5, 460, 5, 3548, 240, 0);
    idle(2);
    @(posedge clk48);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk48);
    rst_n = 1'b1;
    exp_frame = 0;
    tick_full(8'd5, 1, 0, 2048, 480, 61);
    idle(4);
    check("hold_between_ticks_frame", 32'(frame), 32'd1);
    check("hold_between_ticks_flash", 32'(flash_level), 32'd61);

`ifdef DEMO_SEQ_SKIP_EN
    run_to(40, 8'd5);
    skip_pulse();
    tick_full(8'd5, 100, 2, 2444, 480, 0);
    skip_pulse();
    tick_full(8'd5, 169, 3, 3548, 480, 0);
    skip_pulse();
    tick_full(8'd5, 209, 4, 3548, 480, 0);
    skip_pulse();
    tick_full(8'd5, 449, 5, 3548, 240, 0);
    skip_pulse();
    tick_full(8'd5, 1362, 6, 3548, 240, 0);
    skip_pulse();
    tick_full(8'd5, 1431, 7, 2048, 240, 0);
    skip_pulse();
    tick_full(8'd5, 1671, 8, 2048, 0, 0);
    skip_pulse();
    tick_noframe(8'd5, 8, 2048, 0, 0);
`endif

    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demo_sequencer.md
DEMO_SEQUENCER -- requirements
Module: demo_sequencer

Interface
REQ-001 Parameter SCROLL_IN_START, default 100: first frame of the scrolltext entry.
REQ-002 Parameter SCROLL_LEN, default 69: length in frames of the scrolltext entry and exit.
REQ-003 Parameter PLANE_IN_START, default 209: first frame of the plane rise.
REQ-004 Parameter PLANE_LEN, default 240: length in frames of the plane rise and fall.
REQ-005 Parameter PLANE_OUT_END, default 1671: frame at which the plane fall ends.
REQ-006 clk48  in  1: system clock; reset is asynchronous and active-low.
REQ-007 rst_n  in  1: asynchronous active-low reset.
REQ-008 frame_tick  in  1: one-cycle pulse at end of frame (last h_count of last v_count).
REQ-009 songpos  in  8: current audio song position.
REQ-010 frame  out  11: global frame counter.
REQ-011 scene  out  4: current scene state encoding.
REQ-012 scrollh_anim  out  12: scroller horizontal offset.
REQ-013 plane_y_start  out  9: first scanline of the 3D plane.
REQ-014 flash_level  out  6: intro white-flash intensity.
REQ-015 skip_req  in  1: request advance to the next scene; present only with DEMO_SEQ_SKIP_EN.

Function
REQ-016 Scenes SHALL run in this order: FLASH(0), SKY(1), SCROLL_IN(2), PRE_PLANE(3), PLANE_IN(4), HOLD(5), SCROLL_OUT(6), PLANE_OUT(7), END(8); scene outputs this code.
REQ-017 Scene entry frames SHALL be:
- SKY at 32.
- SCROLL_IN at SCROLL_IN_START.
- PRE_PLANE at SCROLL_IN_START+SCROLL_LEN.
- PLANE_IN at PLANE_IN_START.
- HOLD at PLANE_IN_START+PLANE_LEN.
- SCROLL_OUT at PLANE_OUT_END-PLANE_LEN-SCROLL_LEN.
- PLANE_OUT at PLANE_OUT_END-PLANE_LEN.
- END at PLANE_OUT_END.
REQ-018 Internal counter n (9 bits) SHALL hold frames elapsed in the current scene: cleared on scene entry, incremented on each frame_tick otherwise.
REQ-019 On each frame_tick the block SHALL set frame to frame+1, saturating at 2047, and transition scene when the new frame equals the next scene's entry frame.
REQ-020 Restart: a frame_tick while songpos==0 and frame>8 SHALL set frame=0, n=0, scene=FLASH; this takes priority over all transitions and over skip.
REQ-021 END SHALL persist until restart.
REQ-022 scrollh_anim SHALL be:
- 2444+(n<<4) in SCROLL_IN.
- 3548 in PRE_PLANE, PLANE_IN and HOLD.
- 3548+(n<<4) in SCROLL_OUT.
- 2048 in all other scenes.
- All arithmetic modulo 2^12.
REQ-023 plane_y_start SHALL be:
- 480 in FLASH through PRE_PLANE.
- 480-n in PLANE_IN.
- 240 in HOLD and SCROLL_OUT.
- 240-n in PLANE_OUT.
- 0 in END.
REQ-024 flash_level SHALL be 63-(frame[4:0]<<1) in FLASH, and 0 otherwise.
REQ-025 All outputs SHALL be registered and update on the clock edge following frame_tick (1-cycle latency); they SHALL remain constant between ticks.
REQ-026 frame_tick asserted on consecutive cycles SHALL be counted once per asserted cycle; no tick SHALL be lost.

Reset
REQ-027 While rst_n is low:
- frame=0, n=0, scene=FLASH.
- scrollh_anim=2048, plane_y_start=480, flash_level=63.
REQ-028 Reset assertion mid-scene SHALL abort immediately, asynchronously, with no partial update.
REQ-029 The first tick after rst_n deasserts SHALL yield frame=1.

Configuration
REQ-030 Macro DEMO_SEQ_SKIP_EN, when defined, SHALL add the skip_req input and a sticky skip flag.
REQ-031 skip_req pulse SHALL set the sticky skip flag.
REQ-032 On the next frame_tick with the skip flag set, the block SHALL:
- Enter the next scene.
- Set frame to that scene's entry frame.
- Clear n and the flag.
REQ-033 With the skip flag set in END, the frame_tick SHALL clear the flag and leave END unchanged.
REQ-034 Without DEMO_SEQ_SKIP_EN there SHALL be no skip_req port, and sequencing SHALL be purely frame-driven.

Verification
REQ-035 Reset, then 32 ticks with songpos=5 -> flash_level goes 63,61,...,1 over frames 1..31, then scene=SKY with flash_level=0 at frame 32.
REQ-036 Run to frame 100 -> scene=SCROLL_IN, scrollh_anim=2444; at frame 168 scrollh_anim=3532; at frame 169 scene=PRE_PLANE, scrollh_anim=3548.
REQ-037 Run to frames 209/329/449 -> plane_y_start=480/360/240; at frame 1431 scene=PLANE_OUT; at frame 1671 scene=END, plane_y_start=0.
REQ-038 At frame 500, tick with songpos=0 -> frame=0, scene=FLASH, plane_y_start=480; at frame 5, tick with songpos=0 -> frame=6, no restart.
REQ-039 Assert rst_n low between ticks in HOLD -> outputs at reset values with no clock edge required.
REQ-040 DEMO_SEQ_SKIP_EN: skip_req in SKY at frame 40, then a tick -> scene=SCROLL_IN, frame=100, scrollh_anim=2444; skip_req in END, then a tick -> scene stays END.
